// File: rtl/mor1kx_sdpram_fifo_if.sv
// FWFT FIFO user-side bundle: push side (wr_en/wr_data/full),
// pop side (rd_en/rd_data/empty), flush and occupancy count.
interface mor1kx_sdpram_fifo_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic [AW+1:0] count;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  full, rd_data, empty, count
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output full, rd_data, empty, count
  );
endinterface

// File: rtl/mor1kx_sdpram_fifo.sv
// FWFT FIFO controller driving an external bypassed simple dual-port RAM.
// Ports: clk, rst_n, fifo (user bundle), ram_* (RAM address/enable/data).
module mor1kx_sdpram_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mor1kx_sdpram_fifo_if.slave   fifo,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        head_valid_q, head_valid_d;

  logic [AW:0] ram_cnt;
  logic        push;
  logic        pop;
  logic        fetch;

  // Entries sitting in the RAM, not counting the head.
  assign ram_cnt = wr_ptr_q - rd_ptr_q;

  assign fifo.full  = (ram_cnt == DEPTH);
  assign fifo.empty = ~head_valid_q;
  assign fifo.count = {1'b0, ram_cnt}
                    + {{(AW+1){1'b0}}, head_valid_q};
  assign fifo.rd_data = ram_dout;

  assign push = fifo.wr_en & ~fifo.full
              & ~fifo.flush & rst_n;
  assign pop  = fifo.rd_en & head_valid_q
              & ~fifo.flush;

  // Refill the head when it is empty or leaving. With an empty
  // RAM this reads the slot being written; the RAM bypass
  // returns wr_data one cycle later.
  assign fetch = ~fifo.flush & rst_n
               & (~head_valid_q | pop)
               & ((ram_cnt != '0) | push);

  assign ram_we    = push;
  assign ram_waddr = wr_ptr_q[AW-1:0];
  assign ram_din   = fifo.wr_data;
  assign ram_re    = fetch;
  assign ram_raddr = rd_ptr_q[AW-1:0];

  always_comb begin
    wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, fetch};
    head_valid_d = head_valid_q;
    if (fifo.flush) begin
      rd_ptr_d     = wr_ptr_q;
      head_valid_d = 1'b0;
    end else if (fetch) begin
      head_valid_d = 1'b1;
    end else if (pop) begin
      head_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      head_valid_q <= head_valid_d;
    end
  end
endmodule

// File: tb/tb_mor1kx_sdpram_fifo.sv
// Bench for mor1kx_sdpram_fifo with a behavioural bypassed RAM.
// Occupancy model plus data scoreboard queue.
module tb_mor1kx_sdpram_fifo;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int MAXOCC = (1 << AW) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic          ram_we, ram_re;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] mem [1<<AW];

  mor1kx_sdpram_fifo_if #(.AW(AW), .DW(DW)) f ();

  mor1kx_sdpram_fifo #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fifo(f),
    .ram_waddr(ram_waddr),
    .ram_we(ram_we),
    .ram_din(ram_din),
    .ram_raddr(ram_raddr),
    .ram_re(ram_re),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Bypassed SDP RAM: holds dout when re low.
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_din;
    if (ram_re)
      ram_dout <= (ram_we && ram_raddr == ram_waddr)
                ? ram_din : mem[ram_raddr];
  end

  int checks = 0;
  int errors = 0;
  int occ = 0;
  logic [DW-1:0] sb [$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, check, then advance the model.
  task automatic step(input logic w, input logic r,
                      input logic fl,
                      input logic [DW-1:0] d);
    logic ep, eo;
    @(negedge clk);
    f.wr_en = w; f.rd_en = r;
    f.flush = fl; f.wr_data = d;
    #1;
    ep = w && occ != MAXOCC && !fl;
    eo = r && occ != 0 && !fl;
    chk("count", 64'(f.count), 64'(occ));
    chk("empty", 64'(f.empty), 64'(occ == 0));
    chk("full", 64'(f.full), 64'(occ == MAXOCC));
    chk("ram_we", 64'(ram_we), 64'(ep));
    if (occ != 0) chk("head", 64'(f.rd_data), 64'(sb[0]));
    if (fl) chk("flush_re", 64'(ram_re), 64'd0);
    if (fl) begin
      sb.delete();
      occ = 0;
    end else begin
      if (eo) void'(sb.pop_front());
      if (ep) sb.push_back(d);
      occ = occ + int'(ep) - int'(eo);
    end
  endtask

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] d;
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tv [5];

  initial begin
    f.wr_en = 0; f.rd_en = 0;
    f.flush = 0; f.wr_data = '0;

    tv[0] = '{1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 4'd0};
    tv[1] = '{1'b1, 1'b0, 32'hA5A5_0001, 1'b1, 1'b1, 4'd0};
    tv[2] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd1};
    tv[3] = '{1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 4'd1};
    tv[4] = '{1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 4'd1};

    #1;
    chk("rst_empty", 64'(f.empty), 64'd1);
    chk("rst_count", 64'(f.count), 64'd0);
    chk("rst_re", 64'(ram_re), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle pulse, bypass push, head view, pop, pop on empty.
    for (int i = 0; i < 5; i++) begin
      step(tv[i].wr, tv[i].rd, 1'b0, tv[i].d);
      chk("tv_we", 64'(ram_we), 64'(tv[i].we));
      chk("tv_re", 64'(ram_re), 64'(tv[i].re));
      chk("tv_waddr", 64'(ram_waddr), 64'(tv[i].addr));
      chk("tv_raddr", 64'(ram_raddr), 64'(tv[i].addr));
    end

    // Fill to max occupancy, refuse one more, drain in order.
    for (int i = 0; i < 17; i++) step(1, 0, 0, 32'h10 + i);
    step(1, 0, 0, 32'h99);
    chk("full_cnt", 64'(f.count), 64'd17);
    for (int i = 0; i < 17; i++) step(0, 1, 0, '0);
    step(0, 0, 0, '0);

    // Streaming push+pop across pointer wrap.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h100 + i);
    for (int i = 0; i < 40; i++)
      step(1, 1, 0, 32'h200 + i);

    // Head held: nothing should be fetched.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, '0);
      chk("hold_re", 64'(ram_re), 64'd0);
    end

    // Flush with 6 queued, wr/rd also asserted.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h300 + i);
    step(1, 1, 1, 32'hDEAD);
    chk("flush_we", 64'(ram_we), 64'd0);
    step(1, 0, 0, 32'hBEEF_0001);
    step(0, 0, 0, '0);
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);

    // Async reset between edges with 6 queued.
    for (int i = 0; i < 6; i++) step(1, 0, 0, 32'h400 + i);
    @(negedge clk);
    f.wr_en = 1; f.rd_en = 1; f.wr_data = 32'h777;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_empty", 64'(f.empty), 64'd1);
    chk("ar_count", 64'(f.count), 64'd0);
    chk("ar_full", 64'(f.full), 64'd0);
    chk("ar_we", 64'(ram_we), 64'd0);
    chk("ar_re", 64'(ram_re), 64'd0);
    f.wr_en = 0; f.rd_en = 0;
    sb.delete();
    occ = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 32'hCAFE_0002);
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
